// File: rtl/control_fsm.sv
// Four-state instruction sequencer for a small register-file/ALU datapath.
// State and IR are registered; every datapath enable is a decode of (state, IR).
module control_fsm #(
  parameter logic ILLEGAL_ERR = 1'b1
) (
  input  logic       CLKb,
  input  logic       RSTn,
  input  logic       Run,
  input  logic [9:0] INSTR,
  output logic       Ain,
  output logic       Gin,
  output logic       Gout,
  output logic [3:0] FN,
  output logic [3:0] Rin,
  output logic [3:0] Rout,
  output logic       Extern,
  output logic       Busy,
  output logic       Done,
  output logic       Err
);

  typedef enum logic [1:0] {IDLE, T1, T2, T3} state_t;

  localparam logic [3:0] OP_LOAD = 4'b0000;
  localparam logic [3:0] OP_COPY = 4'b0001;
  localparam logic [3:0] OP_INV  = 4'b0100;
  localparam logic [3:0] OP_FLP  = 4'b0101;

  state_t     state;
  logic [9:0] ir;

  logic [3:0] op;
  logic [1:0] rx, ry;
  logic       imm;
  logic       unused_rsvd;
  logic [3:0] rx_oh, ry_oh;
  logic       is_illegal, is_single, is_unary;

  assign op          = ir[9:6];
  assign rx          = ir[5:4];
  assign ry          = ir[3:2];
  assign imm         = ir[1];
  assign unused_rsvd = ir[0];
  assign rx_oh       = 4'b0001 << rx;
  assign ry_oh       = 4'b0001 << ry;

  // 1100..1111 are undefined; they finish in T1 like LOAD/COPY
  assign is_illegal = op[3] & op[2];
  assign is_single  = (op == OP_LOAD) | (op == OP_COPY) | is_illegal;
  assign is_unary   = (op == OP_INV) | (op == OP_FLP);

  always_ff @(posedge CLKb or negedge RSTn) begin
    if (!RSTn) begin
      state <= IDLE;
      ir    <= '0;
    end else begin
      case (state)
        IDLE: if (Run) begin
          ir    <= INSTR;
          state <= T1;
        end
        T1:      state <= is_single ? IDLE : T2;
        T2:      state <= is_unary  ? IDLE : T3;
        default: state <= IDLE;
      endcase
    end
  end

  always_comb begin
    Ain    = 1'b0;
    Gin    = 1'b0;
    Gout   = 1'b0;
    Rin    = '0;
    Rout   = '0;
    Extern = 1'b0;
    Done   = 1'b0;
    Err    = 1'b0;
    Busy   = (state != IDLE);
    FN     = (state == IDLE) ? 4'b0000 : op;
    case (state)
      T1: begin
        if (op == OP_LOAD) begin
          Extern = 1'b1;
          Rin    = rx_oh;
          Done   = 1'b1;
        end else if (op == OP_COPY) begin
          if (imm) Extern = 1'b1;
          else     Rout   = ry_oh;
          Rin  = rx_oh;
          Done = 1'b1;
        end else if (is_illegal) begin
          Done = 1'b1;
          Err  = ILLEGAL_ERR;
        end else if (is_unary) begin
          if (imm) Extern = 1'b1;
          else     Rout   = ry_oh;
          Gin = 1'b1;
        end else begin
          Rout = rx_oh;
          Ain  = 1'b1;
        end
      end
      T2: begin
        if (is_unary) begin
          Gout = 1'b1;
          Rin  = rx_oh;
          Done = 1'b1;
        end else begin
          if (imm) Extern = 1'b1;
          else     Rout   = ry_oh;
          Gin = 1'b1;
        end
      end
      T3: begin
        Gout = 1'b1;
        Rin  = rx_oh;
        Done = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: doc/control_fsm.md
CONTROL_FSM -- requirements
Module: control_fsm

Interface
REQ-001 SHALL have parameter: ILLEGAL_ERR, 1, when 1 an undefined opcode asserts Err; when 0 it completes silently with Done only.
REQ-002 SHALL have port: CLKb  input  1  system clock; all state updates on rising edge.
REQ-003 SHALL have port: RSTn  input  1  asynchronous active-low reset.
REQ-004 SHALL have port: Run  input  1  start request, sampled only in IDLE.
REQ-005 SHALL have port: INSTR  input  10  instruction word {op[3:0], Rx[1:0], Ry[1:0], I, rsvd}.
REQ-006 SHALL have ports: Ain, Gin, Gout  output  1 each  ALU operand-A load, result load, result bus drive.
REQ-007 SHALL have port: FN  output  4  ALU function code.
REQ-008 SHALL have ports: Rin, Rout  output  4 each  one-hot register-file load and bus-drive enables, R0..R3.
REQ-009 SHALL have port: Extern  output  1  drives external data (immediate/load value) onto the bus.
REQ-010 SHALL have ports: Busy, Done, Err  output  1 each  instruction in progress; final cycle; illegal opcode.

Function
REQ-011 SHALL implement states IDLE, T1, T2, T3 in a registered state variable; all other outputs SHALL be combinational decode of state and IR.
REQ-012 In IDLE with Run=1, the block SHALL capture INSTR into a 10-bit IR and go to T1; with Run=0 it SHALL stay in IDLE.
REQ-013 Opcode map (IR[9:6]): 0000 LOAD, 0001 COPY, 0010 ADD, 0011 SUB, 0100 INV, 0101 FLP, 0110 AND, 0111 OR, 1000 XOR, 1001 LSL, 1010 LSR, 1011 ASR, 1100-1111 illegal.
REQ-014 "Source" SHALL mean Extern=1 if IR[1]=1, else Rout[Ry]=1.
REQ-015 LOAD: T1 asserts Extern, Rin[Rx], Done; then IDLE.
REQ-016 COPY: T1 asserts source, Rin[Rx], Done; then IDLE.
REQ-017 Binary ops (0010, 0011, 0110-1011): T1 asserts Rout[Rx] and Ain; T2 asserts source, Gin, FN=op; T3 asserts Gout, Rin[Rx], Done; then IDLE.
REQ-018 Unary ops (INV, FLP): T1 asserts source, Gin, FN=op; T2 asserts Gout, Rin[Rx], Done; then IDLE.
REQ-019 Illegal op: T1 asserts Done, and Err when ILLEGAL_ERR=1, with no enable asserted; then IDLE.
REQ-020 FN SHALL equal IR[9:6] in every non-IDLE state and 4'b0000 in IDLE.
REQ-021 At most one bus driver (Rout bits, Extern, Gout) SHALL be active per cycle; Rin and Rout SHALL each be one-hot or zero.
REQ-022 Busy SHALL be 1 in T1-T3 and 0 in IDLE; Done and Err SHALL be single-cycle pulses.
REQ-023 Latency from Run capture: LOAD/COPY/illegal 2 cycles, unary 3, binary 4, including the IDLE capture cycle.
REQ-024 With Run held high, the next instruction SHALL be captured in the IDLE cycle right after Done, with no extra gap.
REQ-025 Run and INSTR changes while Busy=1 SHALL be ignored; IR SHALL be stable for the whole instruction.
REQ-026 The rsvd bit IR[0] SHALL be ignored; IR[1] SHALL have no effect on LOAD or illegal ops.

Reset
REQ-027 RSTn=0 SHALL immediately force state IDLE, IR=0, and all outputs 0, regardless of the clock.
REQ-028 Reset asserted mid-instruction SHALL abort it with no Rin or Done pulse; after release the block SHALL wait in IDLE for Run.

Verification
REQ-029 Apply INSTR=0x098 (ADD R1,R2) with Run=1 -> T1: Rout=0010, Ain; T2: Rout=0100, Gin, FN=0010; T3: Gout, Rin=0010, Done.
REQ-030 Apply INSTR=0x092 (ADD R1,#imm) -> T2: Extern=1, Rout=0000, FN=0010; T3: Rin=0010, Done.
REQ-031 Apply INSTR=0x170 (FLP R3,R0) -> T1: Rout=0001, Gin, FN=0101; T2: Gout, Rin=1000, Done; Busy low the next cycle.
REQ-032 Apply 0x020 (LOAD R2) then 0x300 (illegal) with Run held high -> Done in consecutive instructions; second asserts Err=1 and no enables; no idle gap beyond the IDLE capture cycle.
REQ-033 Pulse RSTn low during T2 of 0x098 -> all outputs 0 asynchronously; no Rin or Done pulse; after release, Run with 0x020 completes normally.
REQ-034 Every test SHALL check by assertion that at most one bus driver is active and that Rin/Rout are one-hot or zero in every cycle.
